// File: rtl/cache_line_fill_array.sv
// Set-associative cache line data array with a two-cycle pipelined read of one
// chunk from every way and an internal sequencer that writes a whole line into
// one way, one chunk per cycle.
module cache_line_fill_array #(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned SETS    = 128,
  parameter int unsigned CHUNKS  = 4,
  parameter int unsigned CHUNK_W = 128,
  localparam int unsigned LINE_W = CHUNKS * CHUNK_W,
  localparam int unsigned SET_W  = $clog2(SETS),
  localparam int unsigned CHK_W  = $clog2(CHUNKS),
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned DEPTH  = SETS * CHUNKS * WAYS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [SET_W-1:0]        rd_set,
  input  logic [CHK_W-1:0]        rd_chunk,
  output logic [WAYS*CHUNK_W-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    fill_valid,
  output logic                    fill_ready,
  input  logic [SET_W-1:0]        fill_set,
  input  logic [WAY_W-1:0]        fill_way,
  input  logic [LINE_W-1:0]       fill_data,
  output logic                    fill_done,
  output logic                    busy
);

  localparam int unsigned ADDR_W = SET_W + CHK_W + WAY_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SET_W-1:0]    r_fset;
  logic [WAY_W-1:0]    r_fway;
  logic [LINE_W-1:0]   r_fdata;
  logic [CHK_W-1:0]    r_beat;
  logic                w_accept;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [CHUNK_W-1:0]  w_wdata;

  logic [CHUNK_W-1:0]  r_mem [DEPTH];

  logic                r_rd_v;
  logic [SET_W-1:0]    r_rd_set;
  logic [CHK_W-1:0]    r_rd_chk;

  // Fill FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Fill FSM next state and handshake/status outputs; writes and the done
  // pulse are suppressed in a reset cycle so an aborted fill leaves no trace
  always_comb begin
    w_next     = r_state;
    fill_ready = 1'b0;
    busy       = 1'b0;
    fill_done  = 1'b0;
    w_accept   = 1'b0;
    w_we       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        fill_ready = 1'b1;
        if (fill_valid) begin
          w_accept = 1'b1;
          w_next   = S_FILL;
        end
      end
      S_FILL: begin
        busy = 1'b1;
        w_we = !rst;
        if (r_beat == CHK_W'(CHUNKS - 1)) begin
          fill_done = !rst;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the accepted line and step the beat counter through the fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_fset  <= fill_set;
      r_fway  <= fill_way;
      r_fdata <= fill_data;
      r_beat  <= '0;
    end else if (r_state == S_FILL) begin
      if (r_beat == CHK_W'(CHUNKS - 1)) r_beat <= '0;
      else                              r_beat <= r_beat + 1'b1;
    end
  end

  assign w_waddr = {r_fset, r_beat, r_fway};
  assign w_wdata = r_fdata[r_beat*CHUNK_W +: CHUNK_W];

  // Array write port, one chunk per fill beat
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Read stage 1: register the request
  always_ff @(posedge clk) begin
    if (rst) r_rd_v <= 1'b0;
    else     r_rd_v <= rd_en;
    if (rd_en) begin
      r_rd_set <= rd_set;
      r_rd_chk <= rd_chunk;
    end
  end

  // Read stage 2: fetch the chunk from every way; a same-edge write yields old data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= r_rd_v;
      if (r_rd_v) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          rd_data[w*CHUNK_W +: CHUNK_W] <= r_mem[{r_rd_set, r_rd_chk, WAY_W'(w)}];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_line_fill_array.sv
// Directed bench for cache_line_fill_array: default geometry plus a
// 2-way / 8-chunk / 64-bit instance sharing the clock and reset.
module tb_cache_line_fill_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance: WAYS=4, SETS=128, CHUNKS=4, CHUNK_W=128
  logic         d1_rd_en;
  logic [6:0]   d1_rd_set;
  logic [1:0]   d1_rd_chunk;
  logic [511:0] d1_rd_data;
  logic         d1_rd_valid;
  logic         d1_fill_valid;
  logic         d1_fill_ready;
  logic [6:0]   d1_fill_set;
  logic [1:0]   d1_fill_way;
  logic [511:0] d1_fill_data;
  logic         d1_fill_done;
  logic         d1_busy;

  // second instance: WAYS=2, SETS=128, CHUNKS=8, CHUNK_W=64
  logic         d2_rd_en;
  logic [6:0]   d2_rd_set;
  logic [2:0]   d2_rd_chunk;
  logic [127:0] d2_rd_data;
  logic         d2_rd_valid;
  logic         d2_fill_valid;
  logic         d2_fill_ready;
  logic [6:0]   d2_fill_set;
  logic [0:0]   d2_fill_way;
  logic [511:0] d2_fill_data;
  logic         d2_fill_done;
  logic         d2_busy;

  cache_line_fill_array dut (
    .clk(clk), .rst(rst),
    .rd_en(d1_rd_en), .rd_set(d1_rd_set), .rd_chunk(d1_rd_chunk),
    .rd_data(d1_rd_data), .rd_valid(d1_rd_valid),
    .fill_valid(d1_fill_valid), .fill_ready(d1_fill_ready),
    .fill_set(d1_fill_set), .fill_way(d1_fill_way), .fill_data(d1_fill_data),
    .fill_done(d1_fill_done), .busy(d1_busy)
  );

  cache_line_fill_array #(.WAYS(2), .SETS(128), .CHUNKS(8), .CHUNK_W(64)) dut2 (
    .clk(clk), .rst(rst),
    .rd_en(d2_rd_en), .rd_set(d2_rd_set), .rd_chunk(d2_rd_chunk),
    .rd_data(d2_rd_data), .rd_valid(d2_rd_valid),
    .fill_valid(d2_fill_valid), .fill_ready(d2_fill_ready),
    .fill_set(d2_fill_set), .fill_way(d2_fill_way), .fill_data(d2_fill_data),
    .fill_done(d2_fill_done), .busy(d2_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk1(input logic [127:0] base);
    logic [511:0] l;
    for (int c = 0; c < 4; c++) l[c*128 +: 128] = base + 128'(c);
    return l;
  endfunction

  function automatic logic [511:0] mk2(input logic [63:0] base);
    logic [511:0] l;
    for (int c = 0; c < 8; c++) l[c*64 +: 64] = base + 64'(c);
    return l;
  endfunction

  task automatic fill1(input int set, input int way, input logic [511:0] line);
    d1_fill_valid = 1'b1;
    d1_fill_set   = 7'(set);
    d1_fill_way   = 2'(way);
    d1_fill_data  = line;
    tick();
    d1_fill_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic rdchk1(input string tag, input int set, input int chunk, input int way,
                        input logic [127:0] exp);
    d1_rd_en    = 1'b1;
    d1_rd_set   = 7'(set);
    d1_rd_chunk = 2'(chunk);
    tick();
    d1_rd_en = 1'b0;
    tick();
    chk({tag, "_valid"}, 512'(d1_rd_valid), 512'd1);
    chk(tag, 512'(d1_rd_data[way*128 +: 128]), 512'(exp));
  endtask

  task automatic rdchk2(input string tag, input int set, input int chunk, input int way,
                        input logic [63:0] exp);
    d2_rd_en    = 1'b1;
    d2_rd_set   = 7'(set);
    d2_rd_chunk = 3'(chunk);
    tick();
    d2_rd_en = 1'b0;
    tick();
    chk({tag, "_valid"}, 512'(d2_rd_valid), 512'd1);
    chk(tag, 512'(d2_rd_data[way*64 +: 64]), 512'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] la;
    logic [511:0] lb;

    rst = 1'b1;
    d1_rd_en = 1'b0; d1_rd_set = '0; d1_rd_chunk = '0;
    d1_fill_valid = 1'b0; d1_fill_set = '0; d1_fill_way = '0; d1_fill_data = '0;
    d2_rd_en = 1'b0; d2_rd_set = '0; d2_rd_chunk = '0;
    d2_fill_valid = 1'b0; d2_fill_set = '0; d2_fill_way = '0; d2_fill_data = '0;
    tick();
    tick();

    // reset state
    chk("rst_rd_valid", 512'(d1_rd_valid), 512'd0);
    chk("rst_rd_data", d1_rd_data, 512'd0);
    chk("rst_fill_ready", 512'(d1_fill_ready), 512'd1);
    chk("rst_fill_done", 512'(d1_fill_done), 512'd0);
    chk("rst_busy", 512'(d1_busy), 512'd0);
    chk("rst2_rd_data", 512'(d2_rd_data), 512'd0);
    chk("rst2_fill_ready", 512'(d2_fill_ready), 512'd1);
    rst = 1'b0;
    tick();

    // fill set 5 way 2, fill_done only in the fourth cycle after accept
    d1_fill_valid = 1'b1; d1_fill_set = 7'd5; d1_fill_way = 2'd2;
    d1_fill_data = mk1(128'hC0DE_0000);
    tick();
    d1_fill_valid = 1'b0; d1_fill_data = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_fill_done", 512'(d1_fill_done), 512'(i == 3));
      chk("t1_busy", 512'(d1_busy), 512'd1);
      chk("t1_fill_ready", 512'(d1_fill_ready), 512'd0);
      tick();
    end
    chk("t1_done_after", 512'(d1_fill_done), 512'd0);
    chk("t1_ready_after", 512'(d1_fill_ready), 512'd1);
    chk("t1_busy_after", 512'(d1_busy), 512'd0);

    // back-to-back reads of chunks 0..3
    d1_rd_en = 1'b1; d1_rd_set = 7'd5;
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) d1_rd_chunk = 2'(c);
      else       d1_rd_en = 1'b0;
      tick();
      if (c == 0) begin
        chk("t1_rd_valid_lat", 512'(d1_rd_valid), 512'd0);
      end else begin
        chk("t1_rd_valid", 512'(d1_rd_valid), 512'd1);
        chk("t1_rd_way2", 512'(d1_rd_data[2*128 +: 128]), 512'(128'hC0DE_0000 + 128'(c - 1)));
      end
    end
    tick();
    chk("t1_rd_valid_end", 512'(d1_rd_valid), 512'd0);
    chk("t1_rd_hold", 512'(d1_rd_data[2*128 +: 128]), 512'(128'hC0DE_0003));

    // fill_valid held high with two lines queued
    d1_fill_valid = 1'b1; d1_fill_set = 7'd10; d1_fill_way = 2'd0;
    d1_fill_data = mk1(128'hAAAA_0000);
    tick();
    d1_fill_set = 7'd11; d1_fill_way = 2'd3; d1_fill_data = mk1(128'hBBBB_0000);
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_low", 512'(d1_fill_ready), 512'd0);
      tick();
    end
    chk("t2_ready_back", 512'(d1_fill_ready), 512'd1);
    chk("t2_idle_busy", 512'(d1_busy), 512'd0);
    tick();
    chk("t2_second_accept", 512'(d1_busy), 512'd1);
    d1_fill_valid = 1'b0;
    repeat (3) tick();
    chk("t2_second_done", 512'(d1_fill_done), 512'd1);
    tick();
    rdchk1("t2_a_c0", 10, 0, 0, 128'hAAAA_0000);
    rdchk1("t2_a_c3", 10, 3, 0, 128'hAAAA_0003);
    rdchk1("t2_b_c0", 11, 0, 3, 128'hBBBB_0000);
    rdchk1("t2_b_c2", 11, 2, 3, 128'hBBBB_0002);

    // read-during-write returns old data
    fill1(9, 1, mk1(128'h5A5A_0000));
    d1_fill_valid = 1'b1; d1_fill_set = 7'd9; d1_fill_way = 2'd1;
    d1_fill_data = mk1(128'hB5B5_0000);
    tick();
    d1_fill_valid = 1'b0;
    tick();
    d1_rd_en = 1'b1; d1_rd_set = 7'd9; d1_rd_chunk = 2'd2;
    tick();
    tick();
    chk("t3_rdw_valid", 512'(d1_rd_valid), 512'd1);
    chk("t3_rdw_old", 512'(d1_rd_data[1*128 +: 128]), 512'(128'h5A5A_0002));
    d1_rd_en = 1'b0;
    tick();
    chk("t3_rd_new", 512'(d1_rd_data[1*128 +: 128]), 512'(128'hB5B5_0002));
    tick();

    // reset after two beats of a fill over an all-ones line, read in flight
    fill1(20, 0, {512{1'b1}});
    d1_fill_valid = 1'b1; d1_fill_set = 7'd20; d1_fill_way = 2'd0;
    d1_fill_data = mk1(128'h1234_0000);
    tick();
    d1_fill_valid = 1'b0;
    tick();
    d1_rd_en = 1'b1; d1_rd_set = 7'd5; d1_rd_chunk = 2'd0;
    tick();
    d1_rd_en = 1'b0;
    rst = 1'b1;
    chk("t4_done_pre", 512'(d1_fill_done), 512'd0);
    tick();
    chk("t4_ready_rst", 512'(d1_fill_ready), 512'd1);
    chk("t4_busy_rst", 512'(d1_busy), 512'd0);
    chk("t4_done_rst", 512'(d1_fill_done), 512'd0);
    chk("t4_rd_valid_rst", 512'(d1_rd_valid), 512'd0);
    chk("t4_rd_data_rst", d1_rd_data, 512'd0);
    rst = 1'b0;
    tick();
    chk("t4_rd_valid_post", 512'(d1_rd_valid), 512'd0);
    chk("t4_done_post", 512'(d1_fill_done), 512'd0);
    chk("t4_ready_post", 512'(d1_fill_ready), 512'd1);
    rdchk1("t4_c0", 20, 0, 0, 128'h1234_0000);
    rdchk1("t4_c1", 20, 1, 0, 128'h1234_0001);
    rdchk1("t4_c2", 20, 2, 0, {128{1'b1}});
    rdchk1("t4_c3", 20, 3, 0, {128{1'b1}});

    // rd_en 1,0,1 -> rd_valid 1,0,1 two cycles later, data held in the gap
    d1_rd_en = 1'b1; d1_rd_set = 7'd5; d1_rd_chunk = 2'd1;
    tick();
    chk("t5_v0", 512'(d1_rd_valid), 512'd0);
    d1_rd_en = 1'b0;
    tick();
    chk("t5_v1", 512'(d1_rd_valid), 512'd1);
    chk("t5_d1", 512'(d1_rd_data[2*128 +: 128]), 512'(128'hC0DE_0001));
    d1_rd_en = 1'b1; d1_rd_chunk = 2'd2;
    tick();
    chk("t5_v2", 512'(d1_rd_valid), 512'd0);
    chk("t5_hold", 512'(d1_rd_data[2*128 +: 128]), 512'(128'hC0DE_0001));
    d1_rd_en = 1'b0;
    tick();
    chk("t5_v3", 512'(d1_rd_valid), 512'd1);
    chk("t5_d3", 512'(d1_rd_data[2*128 +: 128]), 512'(128'hC0DE_0002));
    tick();
    chk("t5_v4", 512'(d1_rd_valid), 512'd0);

    // 2-way / 8-chunk / 64-bit geometry: single fill and pipelined readback
    la = mk2(64'hC0DE_0000);
    d2_fill_valid = 1'b1; d2_fill_set = 7'd5; d2_fill_way = 1'b1; d2_fill_data = la;
    tick();
    d2_fill_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_fill_done", 512'(d2_fill_done), 512'(i == 7));
      chk("t6_fill_ready", 512'(d2_fill_ready), 512'd0);
      tick();
    end
    chk("t6_ready_after", 512'(d2_fill_ready), 512'd1);
    chk("t6_done_after", 512'(d2_fill_done), 512'd0);
    d2_rd_en = 1'b1; d2_rd_set = 7'd5;
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) d2_rd_chunk = 3'(c);
      else       d2_rd_en = 1'b0;
      tick();
      if (c > 0) begin
        chk("t6_rd_valid", 512'(d2_rd_valid), 512'd1);
        chk("t6_rd_way1", 512'(d2_rd_data[64 +: 64]), 512'(64'hC0DE_0000 + 64'(c - 1)));
      end
    end
    tick();
    chk("t6_rd_valid_end", 512'(d2_rd_valid), 512'd0);

    // 2-way geometry: back-to-back fills with fill_valid held
    la = mk2(64'hAAAA_0000);
    lb = mk2(64'hBBBB_0000);
    d2_fill_valid = 1'b1; d2_fill_set = 7'd12; d2_fill_way = 1'b0; d2_fill_data = la;
    tick();
    d2_fill_set = 7'd13; d2_fill_way = 1'b1; d2_fill_data = lb;
    for (int i = 0; i < 8; i++) begin
      chk("t7_ready_low", 512'(d2_fill_ready), 512'd0);
      tick();
    end
    chk("t7_ready_back", 512'(d2_fill_ready), 512'd1);
    tick();
    chk("t7_second_accept", 512'(d2_busy), 512'd1);
    d2_fill_valid = 1'b0;
    repeat (7) tick();
    chk("t7_second_done", 512'(d2_fill_done), 512'd1);
    tick();
    rdchk2("t7_a_c7", 12, 7, 0, 64'hAAAA_0007);
    rdchk2("t7_b_c0", 13, 0, 1, 64'hBBBB_0000);
    rdchk2("t7_b_c5", 13, 5, 1, 64'hBBBB_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
